multi_lfsr_cipher_core: RTL
===========================

Name: multi_lfsr_cipher_core

Overview:
Parametrised multi-LFSR stream cipher engine. It is the next generation of the fixed three-LFSR 8-bit keystream top.
N Fibonacci LFSRs are combined into one keystream bit per cycle. Whole DATA_W-bit words are encrypted or decrypted bit-serially (LSB first) behind valid/ready handshakes. Key loading, zero-key protection and word-boundary keystream continuity are handled internally, so software or a bench never XORs bits itself.

Parameters:
NUM_LFSR, 3, number of LFSRs (1..8)
LFSR_W, 8, width of each LFSR (4..32)
DATA_W, 8, data word width (1..64)
TAPS, {8'hB8,8'hB8,8'hB8} concatenated NUM_LFSR*LFSR_W, feedback tap mask per LFSR; LFSR k uses slice k
COMBINE, 0, 0 = XOR of all LFSR bit0; 1 = majority of LFSR bit0 (NUM_LFSR odd only, else XOR)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
key  input  NUM_LFSR*LFSR_W  seed; slice k seeds LFSR k
key_load  input  1  single-cycle pulse: load key, abort any word in progress
in_data  input  DATA_W  plaintext or ciphertext word
in_valid  input  1  input word valid
in_ready  output  1  core can accept a word
out_data  output  DATA_W  result word
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
busy  output  1  RUN state active
lfsr_state  output  NUM_LFSR*LFSR_W  live LFSR contents, for debug
keystream  output  1  current combined keystream bit

Behaviour:
- Reset (rst low, async):
  - FSM -> IDLE; all LFSRs 0, which is the unkeyed state.
  - out_data 0, out_valid 0, in_ready 0, busy 0.
  - keyed flag cleared.
- LFSR step, per LFSR: next = {parity(state & TAPS_k), state[LFSR_W-1:1]}; the output bit is state[0].
- Key load:
  - On key_load, each slice is loaded. Any all-zero slice is replaced by 1 to avoid lock-up.
  - keyed is set, the FSM returns to IDLE, out_valid clears, and partial results are discarded.
  - key_load has priority over every other event in the same cycle.
- in_ready = keyed & (state == IDLE) & !key_load. When unkeyed, in_ready stays 0 and no word is ever accepted.
- FSM:
  - IDLE: on in_valid & in_ready, capture in_data into the shift register, bit counter = 0 -> RUN.
  - RUN: each cycle, result[cnt] = din[cnt] ^ keystream, every LFSR steps, cnt++. After DATA_W cycles -> DONE.
  - DONE: out_valid = 1 and out_data holds the result stable; LFSRs are frozen. On out_valid & out_ready -> IDLE.
- Latency: the accept edge is followed by DATA_W RUN cycles. out_valid rises on the edge ending the last RUN cycle, i.e. DATA_W+1 edges after accept.
- Throughput: one word per DATA_W+2 cycles at best. out_ready held high gives one DONE cycle, one IDLE cycle, then the next accept.
- Keystream continuity: LFSRs step only in RUN. Word n+1 continues exactly where word n stopped, so the keystream is independent of stall lengths.
- Backpressure: out_ready low holds DONE indefinitely with out_data and lfsr_state unchanged.
- keystream combiner:
  - COMBINE = 0: XOR of all bit0.
  - COMBINE = 1: 1 when more than NUM_LFSR/2 of the bit0s are 1.
- Symmetry: an identical key and identical word sequence through encryption and then decryption returns the original data, bit-exact.
- Reset mid-RUN: immediate return to the reset state, and the key is lost.
- key_load mid-RUN or mid-DONE: the word is dropped and the new key is active next cycle.
- in_valid while not ready is ignored. The source must hold the word; the core never samples it.

Test Plan:
- Default parameters, keys C3/B9/E6; encrypt 8'hAB, key_load same keys, decrypt the ciphertext -> out_data 8'hAB. Ciphertext matches a bench reference model bit-for-bit, and out_valid rises exactly 9 edges after accept.
- Unkeyed after reset, in_valid = 1 for 20 cycles -> in_ready stays 0, out_valid stays 0, lfsr_state stays 0.
- key slice 2 = 8'h00 -> lfsr_state slice 2 reads 8'h01 after load; the keystream stays non-stuck over 255 steps (period check against the model).
- Stream 4 words with random out_ready stalls of 0–5 cycles -> ciphertext identical to the zero-stall run. lfsr_state is unchanged during every DONE stall.
- key_load asserted in cycle 3 of RUN -> no out_valid for the aborted word; the next word encrypts with a fresh keystream from the new key.
- DATA_W = 16, NUM_LFSR = 5, COMBINE = 1, in_data 16'h0000 -> out_data equals the model's majority keystream. Round-trip decrypt restores 16'h0000 and 16'hFFFF.

Source files
------------

// File: rtl/multi_lfsr_cipher_core.sv
// N Fibonacci LFSRs combined into one keystream bit; DATA_W-bit words XORed LSB first.
// Latency: DATA_W+1 edges from accept (inclusive) to out_valid; one word per DATA_W+2 cycles.
// Backpressure: out_ready low holds DONE with out_data and LFSRs frozen; in_ready low outside keyed IDLE.
module multi_lfsr_cipher_core #(
    parameter int NUM_LFSR = 3,
    parameter int LFSR_W   = 8,
    parameter int DATA_W   = 8,
    parameter logic [NUM_LFSR*LFSR_W-1:0] TAPS = {NUM_LFSR{8'hB8}},
    parameter int COMBINE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LFSR*LFSR_W-1:0] key,
    input  logic                       key_load,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [NUM_LFSR*LFSR_W-1:0] lfsr_state,
    output logic                       keystream
);
    localparam int KW    = NUM_LFSR * LFSR_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic                keyed;
    logic [KW-1:0]       lfsr, lfsr_step, lfsr_seed;
    logic [DATA_W-1:0]   din, res;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          ones;
    logic                ks;
    logic                accept;

    // An all-zero slice would lock its LFSR, so it is seeded with 1 instead.
    always_comb begin
        lfsr_step = '0;
        lfsr_seed = '0;
        for (int k = 0; k < NUM_LFSR; k++) begin
            lfsr_step[k*LFSR_W +: LFSR_W] = {^(lfsr[k*LFSR_W +: LFSR_W] & TAPS[k*LFSR_W +: LFSR_W]),
                                             lfsr[k*LFSR_W+1 +: LFSR_W-1]};
            lfsr_seed[k*LFSR_W +: LFSR_W] = (key[k*LFSR_W +: LFSR_W] == '0) ? LFSR_W'(1)
                                                                            : key[k*LFSR_W +: LFSR_W];
        end
    end

    // XOR of the bit0s equals the parity of their population count.
    always_comb begin
        ones = '0;
        for (int k = 0; k < NUM_LFSR; k++) begin
            ones = ones + 4'(lfsr[k*LFSR_W]);
        end
        if (COMBINE == 1 && (NUM_LFSR % 2) == 1) begin
            ks = (ones > 4'(NUM_LFSR / 2));
        end else begin
            ks = ones[0];
        end
    end

    assign in_ready   = keyed && (state == IDLE) && !key_load;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == DONE);
    assign busy       = (state == RUN);
    assign out_data   = res;
    assign lfsr_state = lfsr;
    assign keystream  = ks;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)         state_nxt = RUN;
            RUN:     if (cnt == LAST)    state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
        if (key_load) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keyed <= 1'b0;
            lfsr  <= '0;
            din   <= '0;
            res   <= '0;
            cnt   <= '0;
        end else if (key_load) begin
            keyed <= 1'b1;
            lfsr  <= lfsr_seed;
            res   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        din <= in_data;
                        res <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    res[cnt] <= din[cnt] ^ ks;
                    lfsr     <= lfsr_step;
                    cnt      <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
